// File: rtl/fifo_param.sv
// Parametrised ENA/RDY method-interface FIFO with flush,
// occupancy output and programmable almost-full flag.
module fifo_param #(
  parameter int WIDTH        = 96,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  input  logic             clear__ENA,
  output logic             clear__RDY,
  output logic [CW-1:0]    count,
  output logic             almost_full
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [IW-1:0]    rindex;
  logic [IW-1:0]    windex;
  logic             enq_fire;
  logic             deq_fire;
  logic [IW-1:0]    rindex_nxt;
  logic [IW-1:0]    windex_nxt;

  assign in_enq__RDY    = (count != CW'(DEPTH));
  assign out_deq__RDY   = (count != '0);
  assign out_first__RDY = out_deq__RDY;
  assign out_first      = storage[rindex];
  assign clear__RDY     = 1'b1;
  assign almost_full    = (count >= CW'(AFULL_THRESH));

  assign enq_fire = in_enq__ENA & in_enq__RDY & ~clear__ENA;
  assign deq_fire = out_deq__ENA & out_deq__RDY & ~clear__ENA;

  // explicit wrap so non-power-of-2 depths work
  assign windex_nxt = (windex == LAST) ? '0 : windex + 1'b1;
  assign rindex_nxt = (rindex == LAST) ? '0 : rindex + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rindex <= '0;
      windex <= '0;
      count  <= '0;
    end else if (clear__ENA) begin
      rindex <= '0;
      windex <= '0;
      count  <= '0;
    end else begin
      if (enq_fire)
        windex <= windex_nxt;
      if (deq_fire)
        rindex <= rindex_nxt;
      if (enq_fire && !deq_fire)
        count <= count + 1'b1;
      else if (deq_fire && !enq_fire)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_fire && !RST)
      storage[windex] <= in_enq_v;
  end

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed plus random stimulus against
// queue-based reference models for a 4x96 and a 3x8 instance.
module tb_fifo_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST;

  logic        e4, d4, c4;
  logic [95:0] v4, f4;
  logic        er4, dr4, fr4, cr4, af4;
  logic [2:0]  n4;

  logic        e3, d3, c3;
  logic [7:0]  v3, f3;
  logic        er3, dr3, fr3, cr3, af3;
  logic [1:0]  n3;

  fifo_param dut4 (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(e4), .in_enq_v(v4), .in_enq__RDY(er4),
    .out_deq__ENA(d4), .out_deq__RDY(dr4),
    .out_first(f4), .out_first__RDY(fr4),
    .clear__ENA(c4), .clear__RDY(cr4),
    .count(n4), .almost_full(af4)
  );

  fifo_param #(.WIDTH(8), .DEPTH(3)) dut3 (
    .CLK(CLK), .RST(RST),
    .in_enq__ENA(e3), .in_enq_v(v3), .in_enq__RDY(er3),
    .out_deq__ENA(d3), .out_deq__RDY(dr3),
    .out_first(f3), .out_first__RDY(fr3),
    .clear__ENA(c3), .clear__RDY(cr3),
    .count(n3), .almost_full(af3)
  );

  int checks = 0;
  int errors = 0;
  logic [95:0] q4[$];
  logic [7:0]  q3[$];

  task automatic chk(input string tag,
                     input logic [95:0] obs,
                     input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit fe4, fd4, fe3, fd3;
    fd4 = d4 && q4.size() > 0 && !c4;
    fe4 = e4 && q4.size() < 4 && !c4;
    fd3 = d3 && q3.size() > 0 && !c3;
    fe3 = e3 && q3.size() < 3 && !c3;
    @(posedge CLK);
    #1;
    if (RST) begin
      q4.delete();
      q3.delete();
    end else begin
      if (c4) q4.delete();
      else begin
        if (fd4) void'(q4.pop_front());
        if (fe4) q4.push_back(v4);
      end
      if (c3) q3.delete();
      else begin
        if (fd3) void'(q3.pop_front());
        if (fe3) q3.push_back(v3);
      end
    end
  endtask

  task automatic check4(input string t);
    chk({t, "_cnt4"}, 96'(n4), 96'(q4.size()));
    chk({t, "_erdy4"}, 96'(er4), 96'(q4.size() != 4));
    chk({t, "_drdy4"}, 96'(dr4), 96'(q4.size() != 0));
    chk({t, "_frdy4"}, 96'(fr4), 96'(q4.size() != 0));
    chk({t, "_af4"}, 96'(af4), 96'(q4.size() >= 3));
    chk({t, "_crdy4"}, 96'(cr4), 96'(1));
    if (q4.size() > 0)
      chk({t, "_first4"}, f4, q4[0]);
  endtask

  task automatic check3(input string t);
    chk({t, "_cnt3"}, 96'(n3), 96'(q3.size()));
    chk({t, "_erdy3"}, 96'(er3), 96'(q3.size() != 3));
    chk({t, "_drdy3"}, 96'(dr3), 96'(q3.size() != 0));
    chk({t, "_af3"}, 96'(af3), 96'(q3.size() >= 2));
    if (q3.size() > 0)
      chk({t, "_first3"}, 96'(f3), 96'(q3[0]));
  endtask

  task automatic idle();
    e4 = 0; d4 = 0; c4 = 0;
    e3 = 0; d3 = 0; c3 = 0;
  endtask

  initial begin
    int nxt, got;
    bit fe, fd;
    RST = 1;
    v4 = '0;
    v3 = '0;
    idle();
    tick();
    RST = 0;
    check4("rst");
    check3("rst");
    chk("rst_cnt4_zero", 96'(n4), 96'(0));

    // fill 1..4
    for (int i = 1; i <= 4; i++) begin
      e4 = 1; v4 = 96'(i);
      tick();
      check4("fill");
      chk("fill_cnt", 96'(n4), 96'(i));
    end
    chk("full_erdy", 96'(er4), 96'(0));

    // overflow ignored
    v4 = 96'hAA;
    tick();
    check4("ovf");
    chk("ovf_head", f4, 96'd1);
    e4 = 0;

    // drain in order
    for (int i = 1; i <= 4; i++) begin
      chk("drain_first", f4, 96'(i));
      d4 = 1;
      tick();
      check4("drain");
    end
    chk("empty_drdy", 96'(dr4), 96'(0));

    // underflow ignored
    tick();
    check4("udf");
    d4 = 0;

    // steady state at count 2 across wrap
    e4 = 1; v4 = 96'd10; tick();
    v4 = 96'd11; tick();
    d4 = 1;
    for (int i = 0; i < 10; i++) begin
      chk("sim_head", f4, 96'(10 + i));
      v4 = 96'(12 + i);
      tick();
      check4("sim");
      chk("sim_cnt", 96'(n4), 96'd2);
    end
    d4 = 0;

    // full boundary concurrency
    v4 = 96'd30; tick();
    v4 = 96'd31; tick();
    check4("bfull");
    d4 = 1; v4 = 96'd99;
    tick();
    chk("bnd_cnt3", 96'(n4), 96'd3);
    d4 = 0; v4 = 96'h55;
    tick();
    chk("bnd_cnt4", 96'(n4), 96'd4);
    e4 = 0; d4 = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3)
        chk("bnd_last", f4, 96'h55);
      tick();
      check4("bdrain");
    end
    d4 = 0;

    // clear priority
    e4 = 1;
    for (int i = 0; i < 3; i++) begin
      v4 = 96'(40 + i);
      tick();
    end
    c4 = 1; d4 = 1; v4 = 96'h77;
    tick();
    chk("clr_cnt", 96'(n4), 96'd0);
    chk("clr_drdy", 96'(dr4), 96'd0);
    check4("clr");
    c4 = 0; d4 = 0; v4 = 96'h11;
    tick();
    chk("clr_first", f4, 96'h11);
    e4 = 0;

    // random 4x96 traffic with occasional flush
    for (int i = 0; i < 80; i++) begin
      e4 = 1'($urandom);
      d4 = 1'($urandom);
      c4 = ($urandom_range(15) == 0);
      v4 = {$urandom, $urandom, $urandom};
      tick();
      check4("rnd4");
    end
    idle();

    // 3x8 stream 0..20 with random handshakes
    nxt = 0;
    got = 0;
    for (int cyc = 0; cyc < 500 && got < 21; cyc++) begin
      e3 = (nxt <= 20) && 1'($urandom);
      d3 = 1'($urandom);
      v3 = 8'(nxt);
      fe = e3 && q3.size() < 3;
      fd = d3 && q3.size() > 0;
      if (fd)
        chk("stream_order", 96'(f3), 96'(got));
      tick();
      if (fe) nxt++;
      if (fd) got++;
      check3("stream");
      checks++;
      assert (n3 <= 2'd3) else begin
        errors++;
        $error("FAIL stream_max obs=%0d exp<=3", n3);
      end
    end
    chk("stream_done", 96'(got), 96'd21);
    idle();

    // mid-stream reset
    e3 = 1; v3 = 8'hA1; tick();
    v3 = 8'hA2; tick();
    chk("pre_rst3", 96'(n3), 96'd2);
    RST = 1; d3 = 1;
    tick();
    RST = 0;
    chk("mid_rst3", 96'(n3), 96'd0);
    chk("mid_rst4", 96'(n4), 96'd0);
    check3("midrst");
    check4("midrst");
    idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised successor to the two-entry method-interface FIFO: WIDTH-bit entries, DEPTH entries.
- Uses all DEPTH slots via an explicit occupancy counter (no sacrificed slot).
- Adds a synchronous flush method, an occupancy output and a programmable almost-full flag.
- Sits between producer/consumer modules using the ENA/RDY method handshake; drop-in replacement where deeper or wider buffering is needed.

Parameters:
- WIDTH, 96, bits per entry (≥1).
- DEPTH, 4, number of entries (≥2; need not be a power of 2).
- AFULL_THRESH, DEPTH-1, almost-full asserts when occupancy ≥ this value (1..DEPTH).
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset, synchronous, active-high.
- in$enq__ENA  in  1  enqueue request; honoured only when in$enq__RDY=1.
- in$enq$v  in  WIDTH  enqueue data.
- in$enq__RDY  out  1  FIFO not full.
- out$deq__ENA  in  1  dequeue request; honoured only when out$deq__RDY=1.
- out$deq__RDY  out  1  FIFO not empty.
- out$first  out  WIDTH  head entry data.
- out$first__RDY  out  1  FIFO not empty (identical to out$deq__RDY).
- clear__ENA  in  1  flush all entries.
- clear__RDY  out  1  constant 1.
- count  out  CW  current occupancy, 0..DEPTH.
- almost_full  out  1  count ≥ AFULL_THRESH.

Behaviour:
- State:
  - rindex, windex: 0..DEPTH-1.
  - count: 0..DEPTH.
  - storage: DEPTH x WIDTH, no reset.
- Reset (RST=1 at a clock edge) sets rindex=0, windex=0, count=0. Resulting outputs:
  - in$enq__RDY=1.
  - out$deq__RDY=0, out$first__RDY=0.
  - count=0, almost_full=0 (almost_full=1 only if AFULL_THRESH=0, which is illegal).
- Reset overrides clear, enq and deq in the same cycle. Reset mid-stream discards contents; storage is not cleared.
- in$enq__RDY = (count != DEPTH). It is purely a function of state; no combinational path from out$deq__ENA.
- out$deq__RDY = out$first__RDY = (count != 0).
- out$first = storage[rindex] (combinational read). Value is undefined (don't-care) when empty; the bench checks it only when RDY=1.
- Effective enqueue: enq_fire = in$enq__ENA & in$enq__RDY & !clear__ENA.
  - storage[windex] <= in$enq$v.
  - windex <= (windex==DEPTH-1) ? 0 : windex+1.
- Effective dequeue: deq_fire = out$deq__ENA & out$deq__RDY & !clear__ENA.
  - rindex <= (rindex==DEPTH-1) ? 0 : rindex+1.
- Count update:
  - enq only: +1.
  - deq only: −1.
  - both or neither: unchanged.
- Latency:
  - Data enqueued at edge N is visible on out$first and out$deq__RDY after edge N (one-cycle latency).
  - No enq-to-first bypass when empty.
- Simultaneous enq+deq:
  - Empty: only enq fires (deq RDY low).
  - Full: only deq fires (enq RDY low); a producer may enqueue the next cycle.
  - Otherwise both fire.
- ENA with RDY low is ignored; no state change, no error flag.
- clear__ENA: rindex<=0, windex<=0, count<=0 at the edge. It takes priority over same-cycle enq/deq, which are dropped.
- Wrap-around: indices wrap DEPTH-1→0 for any DEPTH, including non-power-of-2.
- almost_full derives from registered count; no combinational path from inputs.

Test Plan:
- Reset/fill/drain: after RST, enqueue 1,2,3,4 on consecutive cycles (DEPTH=4) -> count 1..4, in$enq__RDY=0 after 4th; almost_full=1 at count=3. Dequeue 4 times -> out$first 1,2,3,4 in order; out$deq__RDY=0 after last.
- Overflow/underflow ignored: full FIFO, assert in$enq__ENA with v=0xAA -> count stays 4, head still 1. Empty FIFO, assert out$deq__ENA -> count stays 0, indices unchanged.
- Simultaneous enq+deq at count=2 over 10 cycles with incrementing data -> count stays 2, output order strictly preserved across index wrap.
- Full-boundary concurrency: full FIFO, enq_ENA and deq_ENA both high -> only deq fires, count=3. Next cycle enq 0x55 fires -> count=4, 0x55 emerges last.
- Clear priority: count=3, assert clear__ENA with enq_ENA (v=0x77) and deq_ENA -> count=0, out$deq__RDY=0. Next enq 0x11 -> out$first=0x11.
- Non-power-of-2: DEPTH=3, WIDTH=8. Stream 0..20 with random ENA on both sides -> output sequence equals input sequence; count never exceeds 3. Mid-stream RST -> count=0 next cycle.
